// File: rtl/serial_add_defs.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_defs;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic maj(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle between the switch logic and the serial adder.
interface serial_add_if
  import serial_add_defs::*;
#(
  parameter int N = N_DEF
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_carry_ff.sv
// Single carry bit for the serial adder slice.
module serial_carry_ff (
  input  logic clk,
  input  logic clr,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= 1'b0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Load/shift/carry sequencer for an N-bit LSB-first serial adder.
module serial_add_ctrl
  import serial_add_defs::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         clr,
  serial_add_if.slave  bus
);

  localparam int CW = $clog2(N);

  state_t         state;
  state_t         nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-1:0]   sum_q;
  logic           busy_q;
  logic           done_q;
  logic           c;
  logic           c_ld;
  logic           c_d;
  logic           s;
  logic           last;

  always_comb begin
    nxt  = state;
    c_ld = 1'b0;
    c_d  = 1'b0;
    s    = a_sr[0] ^ b_sr[0] ^ c;
    last = (cnt == CW'(N - 1));
    unique case (state)
      IDLE: begin
        if (bus.start) nxt = LOAD;
      end
      LOAD: begin
        nxt  = SHIFT;
        c_ld = 1'b1;
      end
      SHIFT: begin
        c_ld = 1'b1;
        c_d  = maj(a_sr[0], b_sr[0], c);
        if (last) nxt = DONE;
      end
      DONE: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      busy_q <= (nxt == LOAD) || (nxt == SHIFT);
      done_q <= (nxt == DONE);
      unique case (state)
        LOAD: begin
          a_sr  <= bus.a;
          b_sr  <= bus.b;
          sum_q <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum_q <= {s, sum_q[N-1:1]};
          // hold at N-1 so the counter never runs past the last bit
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  serial_carry_ff u_carry (
    .clk (clk),
    .clr (clr),
    .ld  (c_ld),
    .d   (c_d),
    .q   (c)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = c;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl against an arithmetic reference.
module tb_serial_add_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   total = 0;
  int   bad = 0;

  serial_add_if #(.N(N)) bus ();

  serial_add_ctrl #(.N(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation; inj1/inj2 are sample cycles at which start is re-pulsed.
  task automatic run_op(
    input string      tag,
    input logic [3:0] va,
    input logic [3:0] vb,
    input int         inj1,
    input int         inj2
  );
    int         cyc;
    int         nb;
    int         nd;
    int         dcyc;
    logic [4:0] r;
    r = {1'b0, va} + {1'b0, vb};
    @(negedge clk);
    bus.a     = va;
    bus.b     = vb;
    bus.start = 1'b1;
    cyc  = 0;
    nb   = 0;
    nd   = 0;
    dcyc = 0;
    while (cyc < N + 8) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == inj1) || (cyc == inj2);
      if (cyc >= 2) begin
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
      end
      if (bus.busy) nb++;
      if (bus.done) begin
        nd++;
        if (nd == 1) begin
          dcyc = cyc;
          check({tag, "_sum"}, 32'(bus.sum), 32'(r[3:0]));
          check({tag, "_cout"}, 32'(bus.cout), 32'(r[4]));
          check({tag, "_busy_in_done"}, 32'(bus.busy), 0);
        end
      end
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, 32'(dcyc), 32'(N + 2));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(N + 1));
    check({tag, "_done_pulses"}, 32'(nd), 1);
    check({tag, "_sum_hold"}, 32'(bus.sum), 32'(r[3:0]));
    check({tag, "_cout_hold"}, 32'(bus.cout), 32'(r[4]));
  endtask

  initial begin
    int nd;
    int prev;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    #3;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sum", 32'(bus.sum), 0);
    check("rst_cout", 32'(bus.cout), 0);
    @(negedge clk);
    clr = 1'b0;

    run_op("p1", 4'b1011, 4'b0110, 0, 0);
    run_op("p2", 4'b0011, 4'b0100, 0, 0);
    run_op("ripple", 4'b1111, 4'b0001, 0, 0);
    run_op("zero", 4'b0000, 4'b0000, 0, 0);
    run_op("ign", 4'b1101, 4'b0111, 3, N + 2);

    // async clear in the middle of the 2nd shift cycle
    @(negedge clk);
    bus.a     = 4'b1011;
    bus.b     = 4'b0111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_clr_busy", 32'(bus.busy), 1);
    check("pre_clr_cout", 32'(bus.cout), 1);
    #1 clr = 1'b1;
    #1;
    check("clr_busy", 32'(bus.busy), 0);
    check("clr_done", 32'(bus.done), 0);
    check("clr_sum", 32'(bus.sum), 0);
    check("clr_cout", 32'(bus.cout), 0);
    #1 clr = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy || bus.done) nd++;
    end
    check("clr_idle", 32'(nd), 0);
    run_op("post_clr", 4'b0101, 4'b0101, 0, 0);

    // start held high: back-to-back operations
    @(negedge clk);
    bus.a     = 4'b1001;
    bus.b     = 4'b1000;
    bus.start = 1'b1;
    nd   = 0;
    prev = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        check("hold_sum", 32'(bus.sum), 32'd1);
        check("hold_cout", 32'(bus.cout), 1);
        if (nd > 1) check("hold_gap", 32'(cyc - prev), 32'(N + 3));
        prev = cyc;
      end
    end
    bus.start = 1'b0;
    check("hold_count", 32'(nd), 3);
    repeat (3) @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      run_op("rand", 4'($urandom), 4'($urandom), 0,
             int'($urandom_range(0, N + 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
